// File: rtl/lut_table_loader_pkg.sv
// Shared configuration for the programmable neuron LUT: load FSM states and geometry helpers.
// Pure elaboration-time content, no logic; latency and backpressure are defined by its users.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2,
        ERROR   = 2'd3
    } lut_state_e;

    localparam int LUT_STATE_W = 2;

    function automatic int lut_depth(input int in_bits);
        return 1 << in_bits;
    endfunction

    function automatic int lut_epb(input int load_w, input int out_bits);
        return load_w / out_bits;
    endfunction

    function automatic int lut_nbeats(input int in_bits, input int out_bits, input int load_w);
        return (lut_depth(in_bits) * out_bits) / load_w;
    endfunction

    // A beat must hold whole entries and the table must be a whole number of beats.
    function automatic bit lut_cfg_ok(input int in_bits, input int out_bits, input int load_w);
        if (in_bits < 1 || out_bits < 1 || load_w < out_bits) return 1'b0;
        if ((load_w % out_bits) != 0) return 1'b0;
        if (((lut_depth(in_bits) * out_bits) % load_w) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int lut_cnt_w(input int nbeats);
        return (nbeats <= 2) ? 1 : $clog2(nbeats);
    endfunction

endpackage

// File: rtl/lut_table_loader_if.sv
// Bundle of the table-load stream, load status and lookup request/response between host side and LUT.
// Load stream is ready/valid; lookup path has no backpressure and a fixed one-cycle response.
interface lut_table_loader_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int LOAD_W   = 8
) ();

    logic                load_start;
    logic                s_valid;
    logic                s_ready;
    logic [LOAD_W-1:0]   s_data;
    logic                s_last;
    logic                table_ok;
    logic                load_err;
    logic                in_valid;
    logic [IN_BITS-1:0]  in_data;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;

    modport master (
        output load_start, s_valid, s_data, s_last, in_valid, in_data,
        input  s_ready, table_ok, load_err, out_valid, out_data
    );

    modport slave (
        input  load_start, s_valid, s_data, s_last, in_valid, in_data,
        output s_ready, table_ok, load_err, out_valid, out_data
    );

endinterface

// File: rtl/lut_table_loader_dist_ram.sv
// DEPTH x OUT_BITS distributed RAM: one beat of EPB entries written per clock, asynchronous read.
// Write takes effect at the clock edge; read is combinational and is registered by the parent.
module lut_dist_ram #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int EPB      = 8,
    parameter int BEAT_W   = 5
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [BEAT_W-1:0]       wbeat,
    input  logic [EPB*OUT_BITS-1:0] wdata,
    input  logic [IN_BITS-1:0]      raddr,
    output logic [OUT_BITS-1:0]     rdata
);

    localparam int DEPTH = 1 << IN_BITS;

    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [OUT_BITS-1:0] mem [DEPTH];

    // Entry 0 of the beat sits in the LSBs and lands at the lowest address of the beat.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < EPB; k++) begin
                mem[IN_BITS'(int'(wbeat) * EPB + k)] <= wdata[k*OUT_BITS +: OUT_BITS];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lut_table_loader.sv
// Runtime-loadable neuron LUT: fills a distributed RAM from a ready/valid beat stream, then serves lookups.
// Lookup latency 1 cycle, never stalls; s_ready is high only while loading and drops during a restart pulse.
module lut_table_loader
    import lut_cfg_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int LOAD_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    lut_table_loader_if.slave  bus
);

    localparam int DEPTH  = lut_depth(IN_BITS);
    localparam int EPB    = lut_epb(LOAD_W, OUT_BITS);
    localparam int NBEATS = lut_nbeats(IN_BITS, OUT_BITS, LOAD_W);
    localparam int CNT_W  = lut_cnt_w(NBEATS);

    localparam logic [LUT_STATE_W-1:0] ST_EMPTY   = EMPTY;
    localparam logic [LUT_STATE_W-1:0] ST_LOADING = LOADING;
    localparam logic [LUT_STATE_W-1:0] ST_READY   = READY;
    localparam logic [LUT_STATE_W-1:0] ST_ERROR   = ERROR;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    if (!lut_cfg_ok(IN_BITS, OUT_BITS, LOAD_W)) begin : g_bad_cfg
        $error("lut_table_loader: LOAD_W must be a multiple of OUT_BITS and divide DEPTH*OUT_BITS");
    end

    logic [LUT_STATE_W-1:0] state;
    logic [CNT_W-1:0]       beat_cnt;
    logic                   accept;
    logic                   at_last;
    logic                   serve;
    logic [OUT_BITS-1:0]    rd_data;
    logic                   out_valid_q;
    logic [OUT_BITS-1:0]    out_data_q;

    // A restart pulse wins over a beat presented in the same cycle, so that beat is refused.
    assign bus.s_ready  = (state == ST_LOADING) && !bus.load_start;
    assign accept       = bus.s_valid && bus.s_ready;
    assign at_last      = (beat_cnt == LAST_BEAT);
    assign bus.table_ok = (state == ST_READY);
    assign bus.load_err = (state == ST_ERROR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            beat_cnt <= '0;
        end else if (bus.load_start) begin
            state    <= ST_LOADING;
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (bus.s_last) begin
                state <= at_last ? ST_READY : ST_ERROR;
            end else if (at_last) begin
                state <= ST_ERROR;
            end
        end
    end

    lut_dist_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .EPB      (EPB),
        .BEAT_W   (CNT_W)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .wbeat (beat_cnt),
        .wdata (bus.s_data),
        .raddr (bus.in_data),
        .rdata (rd_data)
    );

    // Writes only happen while loading and reads only while ready, so the ports never collide.
    assign serve = bus.in_valid && bus.table_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= serve;
            if (serve) begin
                out_data_q <= rd_data;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_lut_table_loader.sv
// Scoreboard bench for lut_table_loader: a bit-level table model predicts every lookup response.
module tb_lut_table_loader;

    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 1;
    localparam int LOAD_W   = 8;
    localparam int EPB      = LOAD_W / OUT_BITS;
    localparam int DEPTH    = 1 << IN_BITS;
    localparam int NBEATS   = DEPTH * OUT_BITS / LOAD_W;

    typedef struct {
        logic [OUT_BITS-1:0] dat;
        int                  cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   wb;
    bit   exp_ok;
    exp_t sb [$];
    logic [OUT_BITS-1:0] model [DEPTH];

    lut_table_loader_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .LOAD_W(LOAD_W)) bus ();

    lut_table_loader #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .LOAD_W(LOAD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_cycle", cyc, e.cyc);
                check("out_data", 32'(bus.out_data), 32'(e.dat));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        wb     = 0;
        exp_ok = 1'b0;
    endtask

    task automatic send_beat(input logic [LOAD_W-1:0] d, input logic last,
                             input logic exp_rdy, input logic start);
        bus.s_valid    = 1'b1;
        bus.s_data     = d;
        bus.s_last     = last;
        bus.load_start = start;
        #1;
        check("s_ready", 32'(bus.s_ready), 32'(exp_rdy));
        tick();
        bus.s_valid    = 1'b0;
        bus.s_last     = 1'b0;
        bus.load_start = 1'b0;
        if (start) begin
            wb     = 0;
            exp_ok = 1'b0;
        end else if (exp_rdy) begin
            for (int k = 0; k < EPB; k++) model[wb*EPB + k] = d[k*OUT_BITS +: OUT_BITS];
            wb++;
        end
    endtask

    task automatic load_full(input bit rnd, input int idle_before);
        logic [LOAD_W-1:0] d;
        pulse_start();
        for (int b = 0; b < NBEATS; b++) begin
            if (b == idle_before) tick();
            d = rnd ? LOAD_W'($urandom) : LOAD_W'(8'hAA);
            if (b == NBEATS - 1) check("table_ok_before_last", 32'(bus.table_ok), 32'd0);
            send_beat(d, b == NBEATS - 1, 1'b1, 1'b0);
        end
        check("table_ok_after_last", 32'(bus.table_ok), 32'd1);
        exp_ok = 1'b1;
    endtask

    task automatic lookup(input logic [IN_BITS-1:0] a);
        exp_t e;
        check("table_ok", 32'(bus.table_ok), 32'(exp_ok));
        bus.in_valid = 1'b1;
        bus.in_data  = a;
        if (exp_ok) begin
            e.dat = model[a];
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic sweep();
        for (int a = 0; a < DEPTH; a++) lookup(IN_BITS'(a));
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        wb       = 0;
        exp_ok   = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rst            = 1'b1;
        bus.load_start = 1'b0;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.s_last     = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        repeat (3) tick();
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("rst_table_ok", 32'(bus.table_ok), 32'd0);
        check("rst_load_err", 32'(bus.load_err), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        rst = 1'b0;
        tick();

        // Lookups before any load are dropped.
        lookup(8'h20);
        check("empty_out_valid", 32'(bus.out_valid), 32'd0);
        check("empty_s_ready", 32'(bus.s_ready), 32'd0);

        // Constant pattern with an idle gap mid-stream.
        load_full(1'b0, 16);
        lookup(8'h01);
        lookup(8'h00);
        tick();

        // Random table, full back-to-back sweep.
        load_full(1'b1, -1);
        sweep();
        for (int a = 0; a < DEPTH; a++) begin
            if (model[a] != '0) begin
                lookup(IN_BITS'(a));
                break;
            end
        end
        tick();

        // Early last on beat 10.
        pulse_start();
        for (int b = 0; b <= 10; b++) send_beat(LOAD_W'($urandom), b == 10, 1'b1, 1'b0);
        check("early_last_err", 32'(bus.load_err), 32'd1);
        check("early_last_ok", 32'(bus.table_ok), 32'd0);
        lookup(8'h05);
        check("err_drop_out_valid", 32'(bus.out_valid), 32'd0);
        pulse_start();
        check("err_cleared", 32'(bus.load_err), 32'd0);

        // Missing last: 32 beats, no s_last.
        for (int b = 0; b < NBEATS; b++) begin
            if (b == NBEATS - 1) check("no_last_err_before", 32'(bus.load_err), 32'd0);
            send_beat(LOAD_W'($urandom), 1'b0, 1'b1, 1'b0);
        end
        check("no_last_err", 32'(bus.load_err), 32'd1);
        send_beat(LOAD_W'($urandom), 1'b0, 1'b0, 1'b0);

        // Restart together with beat 5, then reset mid-load.
        pulse_start();
        for (int b = 0; b < 5; b++) send_beat(LOAD_W'($urandom), 1'b0, 1'b1, 1'b0);
        send_beat(LOAD_W'($urandom), 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < 3; b++) send_beat(LOAD_W'($urandom), 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        check("mid_rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("mid_rst_table_ok", 32'(bus.table_ok), 32'd0);
        check("mid_rst_load_err", 32'(bus.load_err), 32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
        rst    = 1'b0;
        wb     = 0;
        exp_ok = 1'b0;
        tick();
        lookup(8'h33);
        check("post_rst_drop", 32'(bus.out_valid), 32'd0);

        load_full(1'b1, 7);
        sweep();

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lut_table_loader.md
Name: lut_table_loader

Overview:
- Runtime-programmable replacement for the fixed distributed-ROM neuron LUT; it is the writer side of the truth-table interface.
- Accepts a ready/valid stream of packed truth-table bits, fills a 2^IN_BITS x OUT_BITS distributed RAM, then serves registered neuron lookups from it.
- Sits between the host/config path and a LogicNets layer, so neuron tables can be reloaded without re-synthesis.

Parameters:
IN_BITS, 8, lookup address width; DEPTH = 2^IN_BITS entries
OUT_BITS, 1, width of each table entry
LOAD_W, 8, stream beat width; must be a multiple of OUT_BITS and divide DEPTH*OUT_BITS
(derived) EPB = LOAD_W/OUT_BITS entries per beat; NBEATS = DEPTH/EPB (default 32)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
load_start  in  1  single-cycle pulse: begin a new table load
s_valid  in  1  load beat valid
s_ready  out  1  load beat accepted when s_valid & s_ready
s_data  in  LOAD_W  packed entries; entry k at bits [k*OUT_BITS +: OUT_BITS]
s_last  in  1  marks final beat of a load
table_ok  out  1  table fully and correctly loaded; lookups are served
load_err  out  1  last load was malformed (sticky until next load_start)
in_valid  in  1  lookup request valid
in_data  in  IN_BITS  lookup address (neuron input vector)
out_valid  out  1  lookup result valid
out_data  out  OUT_BITS  table[in_data]

Behaviour:
- Reset values: state=EMPTY, s_ready=0, table_ok=0, load_err=0, out_valid=0, out_data=0, beat counter=0. RAM contents are not cleared.
- State EMPTY:
  - s_ready=0.
  - load_start -> LOADING, beat counter cleared, load_err cleared.
- State LOADING:
  - s_ready=1; table_ok=0.
  - Each accepted beat writes EPB entries to addresses beat*EPB .. beat*EPB+EPB-1, ascending; entry 0 is the LSBs. Write takes effect at the clock edge of acceptance.
  - Counter increments per accepted beat.
  - Accepted beat with s_last=1 and counter==NBEATS-1 -> READY.
  - s_last=1 with counter<NBEATS-1 (early last) -> ERROR. That beat is still written.
  - Counter==NBEATS-1 accepted with s_last=0 (missing last) -> ERROR.
  - load_start while LOADING restarts the load: counter=0, and the beat presented in the same cycle is not accepted (s_ready is forced low that cycle).
- State READY:
  - table_ok=1; s_ready=0.
  - load_start -> LOADING; table_ok drops the next cycle.
- State ERROR:
  - load_err=1, table_ok=0, s_ready=0.
  - load_start -> LOADING.
- Lookup:
  - Latency 1 cycle. out_valid(t+1) = in_valid(t) & table_ok(t); out_data(t+1) = table[in_data(t)].
  - Requests while table_ok=0 are dropped: out_valid=0, out_data holds its previous value.
  - No backpressure on the lookup path.
- Read/write collision: impossible by construction, because lookups are only served in READY and writes only occur in LOADING.
- Reset mid-load: returns to EMPTY. Partial contents are considered invalid (table_ok=0) until a complete reload.

Decomposition:
- Shared package lut_cfg_pkg:
  - state enum {EMPTY, LOADING, READY, ERROR}
  - functions/constants for DEPTH, EPB, NBEATS
  - elaboration-time check of LOAD_W divisibility
- One sub-module: lut_dist_ram, a DEPTH x OUT_BITS distributed RAM.
  - Write port: EPB-wide, beat-aligned.
  - Read port: asynchronous; output registered in the parent.
  - Carries the distributed rom_style/ram_style attribute.

Test Plan:
1. Reset, then in_valid=1, in_data=8'h20 -> out_valid stays 0, table_ok=0, s_ready=0.
2. load_start; 32 beats with s_data=8'hAA, s_last on beat 31 (one idle cycle of s_valid mid-stream) -> table_ok=1 one cycle after the last beat. Then lookup 8'h01 -> out_data=1 and 8'h00 -> out_data=0, each with out_valid exactly one cycle after in_valid.
3. Sweep all 256 addresses back-to-back after loading a random table -> every out_data matches the model, out_valid continuous.
4. s_last asserted on beat 10 -> load_err=1, table_ok=0, subsequent lookups dropped. A following load_start clears load_err.
5. 32 beats with no s_last -> ERROR after beat 31; a 33rd beat sees s_ready=0.
6. load_start pulsed together with beat 5 of a load, then rst asserted after 3 more beats -> restart observed (beat 5 not accepted), then EMPTY with all outputs at reset values. A full reload afterwards yields correct lookups.
